// File: rtl/uart_pkg.sv
// Shared types and timing constants for the UART receive path.
// UART_RX_PARITY_EN adds the PARITY state to the state enum.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam logic [3:0] MID_TICK  = 4'd7;
    localparam logic [3:0] LAST_TICK = 4'd15;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/uart_rx_oversample_if.sv
// Host-side bus of the UART receiver: holding register handshake and error pulses.
// UART_RX_PARITY_EN adds the parity_odd select and the parity_err pulse.
interface uart_rx_oversample_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 overrun;
`ifdef UART_RX_PARITY_EN
    logic                 parity_odd;
    logic                 parity_err;
`endif

    modport master (
        input  rx_ready,
`ifdef UART_RX_PARITY_EN
        input  parity_odd,
        output parity_err,
`endif
        output rx_data, rx_valid, frame_err, overrun
    );

    modport slave (
        output rx_ready,
`ifdef UART_RX_PARITY_EN
        output parity_odd,
        input  parity_err,
`endif
        input  rx_data, rx_valid, frame_err, overrun
    );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs, reset to RESET_VAL.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx_oversample.sv
// 16x oversampling UART receiver with mid-bit sampling and a valid/ready holding register.
// Optional parity stage enabled by defining UART_RX_PARITY_EN.
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_tick,
    input  logic rx,
    output logic busy,
    uart_rx_oversample_if.master bus
);
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int IDX_W  = $clog2(DATA_BITS);

    logic                 rx_s;
    state_t               state, state_nx;
    logic [TICK_W-1:0]    tick_cnt, tick_nx;
    logic [IDX_W-1:0]     bit_idx, idx_nx;
    logic [DATA_BITS-1:0] shreg, sh_nx;
    logic                 deliver, stop_bad;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad, par_nx, par_fire;
`endif

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad  <= 1'b0;
`endif
        end else begin
            state    <= state_nx;
            tick_cnt <= tick_nx;
            bit_idx  <= idx_nx;
            shreg    <= sh_nx;
`ifdef UART_RX_PARITY_EN
            par_bad  <= par_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        tick_nx  = tick_cnt;
        idx_nx   = bit_idx;
        sh_nx    = shreg;
        deliver  = 1'b0;
        stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nx   = par_bad;
        par_fire = 1'b0;
`endif
        if (sample_tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_nx = START;
                        tick_nx  = '0;
                    end
                end
                // A start bit that is high again at its midpoint was a glitch.
                START: begin
                    if (tick_cnt == TICK_W'(MID_TICK)) begin
                        tick_nx  = '0;
                        idx_nx   = '0;
                        state_nx = rx_s ? IDLE : DATA;
                    end else begin
                        tick_nx = tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    tick_nx = tick_cnt + 1'b1;
                    if (tick_cnt == TICK_W'(LAST_TICK)) begin
                        sh_nx   = {rx_s, shreg[DATA_BITS-1:1]};
                        tick_nx = '0;
                        idx_nx  = bit_idx + 1'b1;
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_nx = PARITY;
`else
                            state_nx = STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    tick_nx = tick_cnt + 1'b1;
                    if (tick_cnt == TICK_W'(LAST_TICK)) begin
                        par_nx   = ((^shreg) ^ rx_s) != bus.parity_odd;
                        tick_nx  = '0;
                        state_nx = STOP;
                    end
                end
`endif
                // Leaving at mid-stop-bit lets the next start edge be caught early.
                STOP: begin
                    tick_nx = tick_cnt + 1'b1;
                    if (tick_cnt == TICK_W'(LAST_TICK)) begin
                        tick_nx  = '0;
                        state_nx = IDLE;
                        stop_bad = !rx_s;
`ifdef UART_RX_PARITY_EN
                        par_fire = par_bad;
                        deliver  = rx_s && !par_bad;
`else
                        deliver  = rx_s;
`endif
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // A full holding register only accepts a new byte if it is drained in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rx_data    <= '0;
            bus.rx_valid   <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            bus.parity_err <= 1'b0;
`endif
        end else begin
            bus.frame_err  <= stop_bad;
            bus.overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            bus.parity_err <= par_fire;
`endif
            if (deliver) begin
                if (!bus.rx_valid || bus.rx_ready) begin
                    bus.rx_data  <= shreg;
                    bus.rx_valid <= 1'b1;
                end else begin
                    bus.overrun <= 1'b1;
                end
            end else if (bus.rx_valid && bus.rx_ready) begin
                bus.rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/uart_rx_oversample.md
Name: uart_rx_oversample

Overview:
- UART receiver, the consumer end of the baud-tick path.
- Takes a 1-cycle strobe at 16x the baud rate from the baud generator and recovers 8N1 frames from the asynchronous serial line, sampling at mid-bit.
- Delivers each byte through a valid/ready holding register, with framing-error and overrun flags.
- Sits between the pad-side rx line and the host/FIFO side of the UART.

Parameters:
- DATA_BITS, 8, payload bits per frame (5..8 supported), sent LSB first.
- OVERSAMPLE, 16, ticks per bit period; fixed by the baud generator.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sample_tick  in  1  1-cycle strobe, 16 per bit period; never high on consecutive clocks
- rx  in  1  raw serial input, asynchronous, idle high
- rx_ready  in  1  consumer accepts rx_data this cycle
- rx_data  out  DATA_BITS  received byte; stable while rx_valid=1
- rx_valid  out  1  byte held, waiting for consumer
- frame_err  out  1  1-cycle pulse: stop bit sampled low
- overrun  out  1  1-cycle pulse: frame completed while holding register full
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, active-high) values:
  - Synchronizer flops = 1; state = IDLE; counters = 0.
  - rx_data = 0; rx_valid, frame_err, overrun, busy all 0.
- rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s and are taken only on clocks where sample_tick=1.
- tick_cnt: 4 bits, wraps 15->0. bit_idx: 0..DATA_BITS-1.
- IDLE:
  - On tick with rx_s=0 -> START, tick_cnt=0.
- START:
  - Count ticks. On the tick where tick_cnt==7 (mid start bit):
    - rx_s=0 -> DATA, tick_cnt=0, bit_idx=0.
    - rx_s=1 -> IDLE (glitch rejected). No flag is raised.
- DATA:
  - On the tick where tick_cnt==15 (one bit period after the previous mid-point), shift rx_s into shift register MSB; shift right.
  - Then tick_cnt=0 and bit_idx increments.
  - After bit DATA_BITS-1 -> STOP (or PARITY when the optional feature is enabled).
- STOP:
  - On the tick where tick_cnt==15, sample the stop bit, then -> IDLE. The block leaves mid-stop-bit so it can resync on the next start edge.
  - Stop bit = 1: deliver the byte (see holding register below).
  - Stop bit = 0: frame_err pulses for 1 clk; byte discarded; rx_valid unchanged.
- Holding register:
  - Delivery when rx_valid=0: load rx_data, set rx_valid next clock.
  - rx_valid=1 and rx_ready=1 in a cycle without a delivery: clear rx_valid.
  - Delivery when rx_valid=1 and rx_ready=1 in the same cycle: load new data, rx_valid stays 1, no overrun.
  - Delivery when rx_valid=1 and rx_ready=0: new byte dropped, old byte kept, overrun pulses for 1 clk.
- Latency: rx_valid rises 1 clk after the stop-bit sample tick.
- Bytes are delivered LSB-first assembled, e.g. line bits 1,0,1,0,0,1,0,1 -> 0xA5.
- A sample_tick absent for any number of clocks simply stalls the FSM.
- rx_ready while rx_valid=0 is ignored.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state after DATA, sampled at tick_cnt==15.
  - Adds input parity_odd (1 = odd, 0 = even) and output parity_err (1-clk pulse).
  - On mismatch, parity_err pulses at the stop-bit sample; the byte is discarded as for a framing error.
  - If both parity and stop bit are bad, both flags pulse.
- Undefined: no PARITY state, port or logic; frame is 8N1 (DATA_BITS N1).

Decomposition:
- Package uart_pkg holds:
  - State enum {IDLE, START, DATA, PARITY, STOP}, 3 bits.
  - Constants OVERSAMPLE=16, MID_TICK=7, LAST_TICK=15.
- Sub-module uart_sync2: 2-flop synchronizer with reset value parameter (1 here). Reused by the transmitter's cts path.

Test Plan:
- Bench setup: tick every 4 clk; rx_ready held 1.
  - Send 0xA5 8N1 -> rx_data=0xA5, rx_valid high exactly 1 clk after the stop sample, frame_err=0.
- Glitch: rx low for 5 ticks then high -> state returns IDLE; no rx_valid, no frame_err; next 0x3C frame is received correctly.
- Framing: send 0x5A with stop bit=0 -> frame_err 1-clk pulse; rx_valid stays 0; busy drops after the stop sample.
- Overrun: rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11, rx_valid=1, overrun pulses once.
  - Then rx_ready=1 for 1 clk -> rx_valid=0.
  - Same-cycle accept and delivery -> rx_valid stays 1, rx_data=0x22, no overrun.
- Reset mid-frame: assert rst during DATA bit 3 -> all outputs 0 asynchronously; after release, a fresh 0xFF frame is received intact.
- Parity (with UART_RX_PARITY_EN):
  - parity_odd=0, send 0x07 with parity bit 1 -> rx_data=0x07.
  - Parity bit 0 -> parity_err pulse, no rx_valid.
